// File: rtl/regfile_issue_stage.sv
// regfile_issue_stage
//   Architectural register file plus a one-entry issue stage between decode
//   and execute. Two source operands are read (with writeback bypass) and
//   registered together with the decode fields. A per-register busy
//   scoreboard interlocks RAW and WAW hazards against in-flight writes.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_valid / in_ready             decode-side handshake
//   in_opA, in_opB                  source register addresses
//   in_dest, in_wen                 destination register and write intent
//   in_opcode, in_dmaddr            fields passed through to execute
//   wb_valid, wb_addr, wb_data      writeback port (writes the file, clears busy)
//   out_valid / out_ready           execute-side handshake
//   out_operand_a, out_operand_b    registered operand values
//   out_opcode, out_dest,
//   out_dmaddr, out_wen             registered copies of the decode fields
//   busy                            scoreboard, bit i = write to reg i pending
module regfile_issue_stage #(
  parameter int               DATA_W    = 8,
  parameter int               NREGS     = 8,
  parameter int               ADDR_W    = $clog2(NREGS),
  parameter int               OPC_W     = 4,
  parameter int               DM_W      = 4,
  parameter logic [DATA_W-1:0] INIT_STEP = DATA_W'(8'h22),
  parameter bit               R0_ZERO   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_opA,
  input  logic [ADDR_W-1:0] in_opB,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wen,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DM_W-1:0]   in_dmaddr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_operand_a,
  output logic [DATA_W-1:0] out_operand_b,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [ADDR_W-1:0] out_dest,
  output logic [DM_W-1:0]   out_dmaddr,
  output logic              out_wen,
  output logic [NREGS-1:0]  busy
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] init_val [NREGS];
  logic [NREGS-1:0]  busy_reg;
  logic [NREGS-1:0]  wb_sel;
  logic [NREGS-1:0]  ebusy;
  logic [NREGS-1:0]  set_mask;

  logic              valid_reg;
  logic [DATA_W-1:0] operand_a_reg, operand_b_reg;
  logic [OPC_W-1:0]  opcode_reg;
  logic [ADDR_W-1:0] dest_reg;
  logic [DM_W-1:0]   dmaddr_reg;
  logic              wen_reg;

  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] operand_a_next, operand_b_next;

  // Per-register writeback select and reset value. Register 0 is never
  // written when it is hardwired to zero; the top register resets to all ones.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      assign wb_sel[gi]   = wb_valid && (wb_addr == ADDR_W'(gi)) && !(R0_ZERO && (gi == 0));
      assign init_val[gi] = (gi == NREGS - 1) ? {DATA_W{1'b1}} : DATA_W'(gi) * INIT_STEP;
    end
  endgenerate

  // A writeback landing this cycle already resolves the hazard on its register.
  assign ebusy    = busy_reg & ~wb_sel;
  assign stall    = in_valid && (ebusy[in_opA] || ebusy[in_opB] || (in_wen && ebusy[in_dest]));
  assign in_ready = !reset && !stall && (!valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  function automatic logic [DATA_W-1:0] read_src(input logic [ADDR_W-1:0] src);
    if (R0_ZERO && (src == '0))
      return '0;
    else if (wb_valid && (wb_addr == src))
      return wb_data;
    else
      return regs[src];
  endfunction

  always_comb begin
    operand_a_next = read_src(in_opA);
    operand_b_next = read_src(in_opB);
    set_mask       = '0;
    if (accept && in_wen && !(R0_ZERO && (in_dest == '0)))
      set_mask[in_dest] = 1'b1;
  end

  // Register file and scoreboard. A set on the same register as a
  // same-cycle writeback clear wins, since the new write is still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= init_val[i];
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wb_sel[i])
          regs[i] <= wb_data;
      busy_reg <= (busy_reg & ~wb_sel) | set_mask;
    end
  end

  // Issue stage: loads on accept, empties on drain, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= 1'b0;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      opcode_reg    <= '0;
      dest_reg      <= '0;
      dmaddr_reg    <= '0;
      wen_reg       <= 1'b0;
    end else if (accept) begin
      valid_reg     <= 1'b1;
      operand_a_reg <= operand_a_next;
      operand_b_reg <= operand_b_next;
      opcode_reg    <= in_opcode;
      dest_reg      <= in_dest;
      dmaddr_reg    <= in_dmaddr;
      wen_reg       <= in_wen;
    end else if (valid_reg && out_ready) begin
      valid_reg     <= 1'b0;
    end
  end

  assign out_valid     = valid_reg;
  assign out_operand_a = operand_a_reg;
  assign out_operand_b = operand_b_reg;
  assign out_opcode    = opcode_reg;
  assign out_dest      = dest_reg;
  assign out_dmaddr    = dmaddr_reg;
  assign out_wen       = wen_reg;
  assign busy          = busy_reg;

endmodule

// File: doc/regfile_issue_stage.md
Name: regfile_issue_stage

Overview:
- Parametrised successor of the 8x8 register memory.
- Holds the architectural register file, reads two source operands and registers them into a one-entry issue pipeline stage together with the decode fields (opcode, dest, dmaddr).
- Adds writeback-to-read bypass, an optional hardwired-zero register 0, a per-register busy scoreboard with RAW/WAW interlock, and valid/ready handshakes on both sides.
- Sits between decode and execute; writeback returns through the wb_* port.

Parameters:
- DATA_W, 8, register and operand width.
- NREGS, 8, number of registers (power of two, >=2).
- ADDR_W, $clog2(NREGS), register address width.
- OPC_W, 4, opcode field width.
- DM_W, 4, data-memory address field width.
- INIT_STEP, 8'h22, reset value increment per register index.
- R0_ZERO, 0, 1 = register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts instruction this cycle.
- in_opA, in_opB  input  ADDR_W each  source register addresses.
- in_dest  input  ADDR_W  destination register.
- in_wen  input  1  instruction will write in_dest.
- in_opcode  input  OPC_W  opcode, passed through.
- in_dmaddr  input  DM_W  memory address field, passed through.
- wb_valid  input  1  writeback strobe.
- wb_addr  input  ADDR_W  writeback register.
- wb_data  input  DATA_W  writeback data.
- out_valid  output  1  issued instruction held.
- out_ready  input  1  execute accepts.
- out_operand_a, out_operand_b  output  DATA_W each  source operand values.
- out_opcode, out_dest, out_dmaddr, out_wen  output  field widths  registered copies of the input fields.
- busy  output  NREGS  scoreboard, bit i = write to reg i outstanding.

Behaviour:
- Reset (sync, highest priority, aborts any held instruction):
  - reg[i] = (i*INIT_STEP) mod 2^DATA_W for i < NREGS-1; reg[NREGS-1] = all ones; reg[0] = 0.
  - busy = 0, out_valid = 0, all out_* payload = 0.
  - in_ready is low during the reset cycle.
- Writeback:
  - wb_valid writes reg[wb_addr] = wb_data at the edge and clears busy[wb_addr].
  - With R0_ZERO=1 and wb_addr=0 the write is dropped.
- Effective busy: ebusy[r] = busy[r] & !(wb_valid & wb_addr==r). A same-cycle writeback releases the hazard.
- Stall condition, evaluated only when in_valid: ebusy[in_opA] | ebusy[in_opB] | (in_wen & ebusy[in_dest]).
- in_ready = !reset & !stall & (!out_valid | out_ready). It is combinational and may depend on in_*; no combinational path from in_valid to out_*.
- Accept (in_valid & in_ready):
  - Stage loads next edge; out_valid = 1; latency 1 cycle.
  - Operand x = wb_data if wb_valid & wb_addr==src (and not R0_ZERO zero-reg case), else reg[src]. Reg 0 reads 0 when R0_ZERO=1.
  - If in_wen (and not R0_ZERO & dest 0), busy[in_dest] is set. A set on the same register as a same-cycle writeback clear takes the set.
- Hold: out_valid & !out_ready means all out_* are stable; later writebacks do not alter held operands.
- Drain: out_valid & out_ready & no accept gives out_valid = 0 next cycle. Accept and drain in the same cycle give back-to-back issue.
- Simultaneous opA==opB is legal and both outputs are identical.

Test Plan:
- Reset with defaults, then issue opA=1, opB=7 -> after 1 cycle out_operand_a=8'h22, out_operand_b=8'hFF, out_valid=1, busy=0.
- Issue dest=3, in_wen=1 -> busy[3]=1. Next instruction reads opA=3: in_ready=0 until wb_valid, wb_addr=3, wb_data=8'h5A. Accepted that same cycle with out_operand_a=8'h5A and busy[3]=0.
- out_ready=0 for 4 cycles with a held instruction while wb writes its source register -> outputs unchanged. in_ready=0 throughout; issue proceeds when out_ready=1.
- R0_ZERO=1: wb_addr=0, wb_data=8'hAA, then read reg 0 -> operand 0. Issue dest=0, in_wen=1 -> busy stays 0.
- WAW: two back-to-back writes to dest=5 -> second stalls until wb clears busy[5]. Reset asserted mid-stall -> out_valid=0, busy=0, reg[5]=8'hAA.
- DATA_W=16, NREGS=16 -> reset reg[2]=16'h0044, reg[15]=16'hFFFF. Continuous back-to-back issue with out_ready=1 sustains 1 instruction per cycle.
